// File: rtl/dll_pkg.sv
// Shared types for the DLL loop controller: FSM state and step encodings.
package dll_pkg;

  // Encodings match the state_o debug port.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StEval   = 2'd3
  } dll_state_e;

  typedef enum logic [1:0] {
    StepNone = 2'd0,
    StepUp   = 2'd1,
    StepDn   = 2'd2
  } dll_step_e;

endpackage

// File: rtl/dll_vote_filter.sv
// Per-window early/late vote counters and the threshold step decision.
module dll_vote_filter
  import dll_pkg::*;
#(
  parameter int unsigned FILT_N = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      sample,
  input  logic      eval,
  input  logic      early,
  input  logic      late,
  output dll_step_e step,
  output logic      window_done
);

  localparam int unsigned SW = (FILT_N > 1) ? $clog2(FILT_N) : 1;
  localparam int unsigned CW = SW + 1;
  localparam int unsigned DW = SW + 2;
  localparam logic signed [DW-1:0] THR = DW'(THRESH);

  logic [SW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        early_q, early_d;
  logic [CW-1:0]        late_q, late_d;
  logic signed [DW-1:0] diff;

  // Vote counter state; a synchronous reset drops any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      early_q <= '0;
      late_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      early_q <= early_d;
      late_q  <= late_d;
    end
  end

  // Count one sample per SAMPLE cycle; ambiguous samples advance the index only.
  always_comb begin
    idx_d   = idx_q;
    early_d = early_q;
    late_d  = late_q;
    if (clr || eval) begin
      idx_d   = '0;
      early_d = '0;
      late_d  = '0;
    end else if (sample) begin
      idx_d = idx_q + 1'b1;
      if (early && !late) early_d = early_q + 1'b1;
      if (late && !early) late_d = late_q + 1'b1;
    end
  end

  assign window_done = sample && (idx_q == SW'(FILT_N - 1));
  assign diff        = $signed({1'b0, early_q}) - $signed({1'b0, late_q});

  // Majority decision from the completed window, consumed in EVAL.
  always_comb begin
    step = StepNone;
    if (diff >= THR) begin
      step = StepUp;
    end else if (diff <= -THR) begin
      step = StepDn;
    end
  end

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL loop controller: filters phase-detector votes, steps the delay code,
// flags saturation at the code bounds and detects lock.
module dll_lock_ctrl
  import dll_pkg::*;
#(
  parameter int unsigned CODE_W       = 6,
  parameter int unsigned CODE_INIT    = 32,
  parameter int unsigned FILT_N       = 8,
  parameter int unsigned THRESH       = 4,
  parameter int unsigned SETTLE       = 2,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              pd_early_i,
  input  logic              pd_late_i,
  output logic [CODE_W-1:0] code_o,
  output logic              locked_o,
  output logic              sat_o,
  output logic [1:0]        state_o
);

  localparam int unsigned SETW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int unsigned LW          = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

  dll_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              locked_q, locked_d;
  logic              sat_q, sat_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  dll_step_e         prev_step_q, prev_step_d;
  logic [SETW-1:0]   settle_q, settle_d;

  logic      sample_en;
  logic      eval_en;
  logic      filt_clr;
  logic      window_done;
  dll_step_e step;
  logic      sat_hit;
  logic      code_change;
  logic      trending;

  dll_vote_filter #(
    .FILT_N(FILT_N),
    .THRESH(THRESH)
  ) u_vote_filter (
    .clk        (clk),
    .rst        (rst),
    .clr        (filt_clr),
    .sample     (sample_en),
    .eval       (eval_en),
    .early      (pd_early_i),
    .late       (pd_late_i),
    .step       (step),
    .window_done(window_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; disable overrides every state.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = (SETTLE == 0) ? StSample : StSettle;
        StSettle: if (settle_q == SETW'(SETTLE_LAST)) state_d = StSample;
        StSample: if (window_done) state_d = StEval;
        StEval: begin
          // Only a real code change needs the delay line to settle again.
          if (code_change && (SETTLE != 0)) state_d = StSettle;
          else                              state_d = StSample;
        end
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: filter strobes and debug state.
  always_comb begin
    sample_en = 1'b0;
    eval_en   = 1'b0;
    filt_clr  = !en_i;
    state_o   = state_q;
    unique case (state_q)
      StIdle:   filt_clr  = 1'b1;
      StSettle: filt_clr  = !en_i;
      StSample: sample_en = en_i;
      StEval:   eval_en   = en_i;
      default:  filt_clr  = 1'b1;
    endcase
  end

  // Loop datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q      <= CODE_W'(CODE_INIT);
      locked_q    <= 1'b0;
      sat_q       <= 1'b0;
      lock_cnt_q  <= '0;
      prev_step_q <= StepNone;
      settle_q    <= '0;
    end else begin
      code_q      <= code_d;
      locked_q    <= locked_d;
      sat_q       <= sat_d;
      lock_cnt_q  <= lock_cnt_d;
      prev_step_q <= prev_step_d;
      settle_q    <= settle_d;
    end
  end

  assign sat_hit = eval_en && (((step == StepUp) && (code_q == CODE_MAX)) ||
                               ((step == StepDn) && (code_q == '0)));
  assign code_change = eval_en && (step != StepNone) && !sat_hit;
  assign trending    = (step != StepNone) && (step == prev_step_q);

  // Code stepping, saturation flag and lock tracking, all resolved in EVAL.
  always_comb begin
    code_d      = code_q;
    locked_d    = locked_q;
    sat_d       = sat_q;
    lock_cnt_d  = lock_cnt_q;
    prev_step_d = prev_step_q;
    settle_d    = '0;
    if (!en_i || (state_q == StIdle)) begin
      // Code is held across disable so the loop resumes where it left off.
      locked_d    = 1'b0;
      sat_d       = 1'b0;
      lock_cnt_d  = '0;
      prev_step_d = StepNone;
    end else begin
      if (state_q == StSettle) settle_d = settle_q + 1'b1;
      if (eval_en) begin
        prev_step_d = step;
        sat_d       = sat_hit;
        if (code_change) begin
          code_d = (step == StepUp) ? code_q + 1'b1 : code_q - 1'b1;
        end
        // Pinning at a bound counts as trending: the loop still wants to move.
        if (trending || sat_hit) begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end else begin
          if (lock_cnt_q != LW'(LOCK_WINDOWS)) lock_cnt_d = lock_cnt_q + 1'b1;
          locked_d = (lock_cnt_d == LW'(LOCK_WINDOWS));
        end
      end
    end
  end

  assign code_o   = code_q;
  assign locked_o = locked_q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Self-checking bench for dll_lock_ctrl with default parameters.
module tb_dll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic       pd_early_i;
  logic       pd_late_i;
  logic [5:0] code_o;
  logic       locked_o;
  logic       sat_o;
  logic [1:0] state_o;

  dll_lock_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .pd_early_i(pd_early_i),
    .pd_late_i (pd_late_i),
    .code_o    (code_o),
    .locked_o  (locked_o),
    .sat_o     (sat_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    bit sat;
    bit locked;
    int nstate;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the loop, driven from the spec behaviour.
  int m_code;
  int m_prev;
  int m_lock;

  task automatic model_eval(input int e, input int l);
    int  diff;
    int  step;
    bit  sat;
    bit  changed;
    bit  trend;
    exp_t x;
    diff = e - l;
    step = (diff >= 4) ? 1 : ((diff <= -4) ? -1 : 0);
    sat = ((step == 1) && (m_code == 63)) || ((step == -1) && (m_code == 0));
    changed = (step != 0) && !sat;
    if (changed) m_code = m_code + step;
    trend = (step != 0) && (step == m_prev);
    if (trend || sat) m_lock = 0;
    else if (m_lock < 4) m_lock = m_lock + 1;
    m_prev = step;
    x.code = m_code;
    x.sat = sat;
    x.locked = (m_lock == 4);
    x.nstate = changed ? 1 : 2;
    sbq.push_back(x);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en_i = 1'b1;
    pd_early_i = 1'b0;
    pd_late_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_code = 32;
    m_prev = 0;
    m_lock = 0;
    sbq.delete();
  endtask

  task automatic wait_sample(input string name);
    for (int i = 0; i < 30; i++) begin
      if (state_o === 2'd2) break;
      @(negedge clk);
    end
    if (state_o !== 2'd2) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for SAMPLE, state=%0d", name, state_o);
    end
  endtask

  // Drives one full window (early votes, late votes, then no-vote fill) and
  // checks the result popped from the scoreboard one cycle after EVAL.
  task automatic do_window(input string name, input int e, input int l);
    exp_t x;
    wait_sample(name);
    for (int i = 0; i < 8; i++) begin
      if (i < e) begin
        pd_early_i = 1'b1; pd_late_i = 1'b0;
      end else if (i < e + l) begin
        pd_early_i = 1'b0; pd_late_i = 1'b1;
      end else begin
        pd_early_i = i[0]; pd_late_i = i[0];
      end
      @(negedge clk);
    end
    pd_early_i = 1'b0;
    pd_late_i = 1'b0;
    checks++;
    if (state_o !== 2'd3) begin
      errors++;
      $display("FAIL %s eval_state: got %0d want 3", name, state_o);
    end
    model_eval(e, l);
    @(negedge clk);
    x = sbq.pop_front();
    checks++;
    if (code_o !== 6'(x.code)) begin
      errors++;
      $display("FAIL %s code: got %0d want %0d", name, code_o, x.code);
    end
    checks++;
    if (sat_o !== x.sat) begin
      errors++;
      $display("FAIL %s sat: got %0b want %0b", name, sat_o, x.sat);
    end
    checks++;
    if (locked_o !== x.locked) begin
      errors++;
      $display("FAIL %s locked: got %0b want %0b", name, locked_o, x.locked);
    end
    checks++;
    if (state_o !== 2'(x.nstate)) begin
      errors++;
      $display("FAIL %s next_state: got %0d want %0d", name, state_o, x.nstate);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (code_o !== 6'd32) begin
      errors++; $display("FAIL reset_code: got %0d want 32", code_o);
    end
    checks++;
    if ({locked_o, sat_o} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b want 00", {locked_o, sat_o});
    end
    checks++;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state_o);
    end
    rst = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      checks++;
      if (state_o !== ((t < 3) ? 2'd1 : 2'd2)) begin
        errors++;
        $display("FAIL reset_seq t=%0d: got %0d want %0d", t, state_o, (t < 3) ? 1 : 2);
      end
    end
  endtask

  task automatic test_constant_early();
    logic [5:0] last;
    int         n_chg;
    int         want_t[2];
    exp_t       x;
    want_t[0] = 12;
    want_t[1] = 23;
    apply_reset();
    pd_early_i = 1'b1;
    model_eval(8, 0);
    model_eval(8, 0);
    last = code_o;
    n_chg = 0;
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      checks++;
      if (locked_o !== 1'b0) begin
        errors++; $display("FAIL const_early locked t=%0d: got %0b want 0", t, locked_o);
      end
      if (code_o !== last && n_chg < 2) begin
        x = sbq.pop_front();
        checks++;
        if (t != want_t[n_chg]) begin
          errors++;
          $display("FAIL const_early timing: change at t=%0d want t=%0d", t, want_t[n_chg]);
        end
        checks++;
        if (code_o !== 6'(x.code) || state_o !== 2'(x.nstate)) begin
          errors++;
          $display("FAIL const_early step: got code %0d state %0d want code %0d state %0d",
                   code_o, state_o, x.code, x.nstate);
        end
        n_chg++;
        last = code_o;
      end
    end
    checks++;
    if (n_chg != 2) begin
      errors++; $display("FAIL const_early count: got %0d changes want 2", n_chg);
    end
    pd_early_i = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 31; i++) do_window("sat_ramp", 8, 0);
    do_window("sat_hit", 8, 0);
    checks++;
    if (sat_o !== 1'b1 || code_o !== 6'd63 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_pin: got sat %0b code %0d locked %0b want 1 63 0", sat_o, code_o,
               locked_o);
    end
    do_window("sat_release", 0, 8);
    checks++;
    if (sat_o !== 1'b0 || code_o !== 6'd62) begin
      errors++;
      $display("FAIL sat_clear: got sat %0b code %0d want 0 62", sat_o, code_o);
    end
  endtask

  task automatic test_threshold();
    apply_reset();
    do_window("thr_diff2", 5, 3);
    do_window("thr_diff4", 6, 2);
    do_window("thr_both", 0, 0);
    do_window("thr_3early", 3, 0);
    do_window("thr_4late", 0, 4);
    checks++;
    if (code_o !== 6'd32) begin
      errors++; $display("FAIL thr_final: got %0d want 32", code_o);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    do_window("lock_w1", 8, 0);
    do_window("lock_w2", 0, 8);
    do_window("lock_w3", 8, 0);
    do_window("lock_w4", 0, 8);
    checks++;
    if (locked_o !== 1'b1 || code_o !== 6'd32) begin
      errors++;
      $display("FAIL lock_set: got locked %0b code %0d want 1 32", locked_o, code_o);
    end
    do_window("lock_t1", 8, 0);
    do_window("lock_t2", 8, 0);
    checks++;
    if (locked_o !== 1'b0 || code_o !== 6'd34) begin
      errors++;
      $display("FAIL lock_drop: got locked %0b code %0d want 0 34", locked_o, code_o);
    end
  endtask

  task automatic test_disable();
    exp_t x;
    apply_reset();
    for (int i = 0; i < 8; i++) do_window("dis_ramp", 8, 0);
    wait_sample("dis_part");
    pd_early_i = 1'b1;
    repeat (5) @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    m_prev = 0;
    m_lock = 0;
    checks++;
    if (state_o !== 2'd0 || code_o !== 6'd40 || locked_o !== 1'b0 || sat_o !== 1'b0) begin
      errors++;
      $display("FAIL dis_idle: got state %0d code %0d locked %0b sat %0b want 0 40 0 0",
               state_o, code_o, locked_o, sat_o);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== 2'd0 || code_o !== 6'd40) begin
      errors++; $display("FAIL dis_hold: got state %0d code %0d want 0 40", state_o, code_o);
    end
    en_i = 1'b1;
    model_eval(8, 0);
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (t == 3) begin
        checks++;
        if (state_o !== 2'd2) begin
          errors++; $display("FAIL dis_resume_state: got %0d want 2", state_o);
        end
      end
      if (t == 11) begin
        checks++;
        if (code_o !== 6'd40) begin
          errors++; $display("FAIL dis_full_window: got %0d want 40 at t=11", code_o);
        end
      end
    end
    x = sbq.pop_front();
    checks++;
    if (code_o !== 6'(x.code) || state_o !== 2'(x.nstate)) begin
      errors++;
      $display("FAIL dis_step: got code %0d state %0d want code %0d state %0d", code_o,
               state_o, x.code, x.nstate);
    end
    pd_early_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant_early();
    test_saturation();
    test_threshold();
    test_lock();
    test_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/dll_lock_ctrl.md
Name: dll_lock_ctrl

Overview:
Digital loop controller for the DLL. It sits directly downstream of the phase detector and upstream of the digitally controlled delay line. It majority-filters early/late decisions over fixed windows and steps the delay code up or down, with saturation handling and lock detection. Its code output drives the delay-line select inside the top-level wrapper.

Parameters:
CODE_W, 6, delay code width
CODE_INIT, 32, code loaded on reset (mid-range)
FILT_N, 8, samples per filter window; power of 2, at least 2
THRESH, 4, minimum |early_cnt - late_cnt| that causes a step; range 1..FILT_N
SETTLE, 2, blanking cycles after a code change; 0 is allowed
LOCK_WINDOWS, 4, consecutive non-trending windows required to assert lock

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en_i  in  1  loop enable
pd_early_i  in  1  phase detector: delayed clock leads the reference, so delay must increase
pd_late_i  in  1  phase detector: delayed clock lags the reference, so delay must decrease
code_o  out  CODE_W  delay-line select, registered
locked_o  out  1  loop locked, registered
sat_o  out  1  code pinned at a bound while the loop demands more, registered
state_o  out  2  FSM state for debug: IDLE=0, SETTLE=1, SAMPLE=2, EVAL=3

Behaviour:
- Reset (sampled on clk):
  - code_o=CODE_INIT, locked_o=0, sat_o=0, state IDLE.
  - All counters are 0.
  - Reset mid-window discards the partial window.
- IDLE: when en_i=1, go to SETTLE, or to SAMPLE if SETTLE=0. Otherwise stay.
- en_i=0 in any state:
  - Go to IDLE next cycle.
  - code_o is held, not reloaded.
  - locked_o and sat_o clear.
  - Window and lock counters clear.
- SETTLE: count SETTLE cycles, ignoring the PD inputs, then go to SAMPLE.
- SAMPLE: each cycle takes one sample.
  - early=1, late=0 increments early_cnt.
  - late=1, early=0 increments late_cnt.
  - Both high or both low: no vote, but the sample still counts toward FILT_N.
  - After the FILT_N-th sample cycle, go to EVAL.
- EVAL, one cycle. diff = early_cnt - late_cnt, signed, width clog2(FILT_N)+2.
  - diff >= THRESH: step = +1. diff <= -THRESH: step = -1. Otherwise step = 0.
  - Step +1 with code = 2^CODE_W-1, or step -1 with code = 0: code unchanged, sat_o=1, treated as a trending step for lock purposes.
  - Any applied step, or a step of 0, clears sat_o.
  - The new code_o is visible on the cycle after EVAL.
  - Next state is SETTLE if the code changed, otherwise SAMPLE.
  - early_cnt and late_cnt clear.
- Step period under constant stimulus: FILT_N + 1 + SETTLE cycles (11 with defaults).
- Lock detection:
  - A window is trending if its step is nonzero and equals the previous window's nonzero step.
  - Any other window (step 0, a reversal, or the first step after IDLE) increments lock_cnt, saturating at LOCK_WINDOWS.
  - locked_o=1 when lock_cnt == LOCK_WINDOWS; it updates with code_o.
  - A trending window or saturation clears lock_cnt and locked_o.
  - The previous-step memory clears in IDLE.
- Code arithmetic never wraps.

Decomposition:
- Package dll_pkg holds:
  - the state enum (IDLE/SETTLE/SAMPLE/EVAL, 2 bits);
  - the step encoding (STEP_NONE/UP/DN).
- The FSM and lock tracking live in dll_lock_ctrl.
- One sub-module, dll_vote_filter: per-window early/late counters, producing the step decision and a window-done pulse.

Test Plan:
1. Reset: rst=1 for 3 cycles with en_i=1 -> code_o=32, locked_o=0, sat_o=0, state_o=0. After rst drops: SETTLE for 2 cycles, then SAMPLE.
2. Constant early (early=1, late=0): code_o goes 32->33->34, one step every 11 cycles. First change lands 1 cycle after the first EVAL. locked_o stays 0.
3. Saturation: early held until code_o=63. Next EVAL -> sat_o=1, code_o stays 63, locked_o=0. Then late held -> sat_o=0, code_o=62.
4. Threshold: window of 5 early + 3 late (diff 2) -> no change, next state SAMPLE. Window of 6 early + 2 late (diff 4) -> +1. Window of all-both-high -> no change.
5. Lock: alternate early-window and late-window for 4 windows -> locked_o=1 after the 4th EVAL, code dithering 32/33. Then two consecutive early windows -> locked_o=0 after the second.
6. Mid-window disable: en_i=0 at sample 5 with code_o=40 -> IDLE next cycle, code_o stays 40, locked_o=0. Re-enable -> a full 8-sample window is required before the next step.
